// File: rtl/lia_sweep_sequencer.sv
// lia_sweep_sequencer: steps the generator phase increment, settles, averages 2^k LIA samples per step.
module lia_sweep_sequencer #(
  parameter int DATA_W   = 14,
  parameter int PHASE_W  = 32,
  parameter int MAX_LOG2 = 12
) (
  input  logic               dac_clk_i,
  input  logic               dac_rstn_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [PHASE_W-1:0] f_start_i,
  input  logic [PHASE_W-1:0] f_step_i,
  input  logic [15:0]        n_steps_i,
  input  logic [23:0]        settle_i,
  input  logic [3:0]         avg_log2_i,
  input  logic [DATA_W-1:0]  lia_data_i,
  input  logic               lia_valid_i,
  output logic [PHASE_W-1:0] phase_inc_o,
  output logic               gen_en_o,
  output logic               busy_o,
  output logic               res_valid_o,
  output logic [DATA_W-1:0]  res_data_o,
  output logic [15:0]        res_index_o,
  output logic               done_o
);
  localparam int ACC_W = DATA_W + MAX_LOG2 + 1;
  localparam int CNT_W = MAX_LOG2 + 1;
  typedef enum logic [2:0] {IDLE, SETTLE, ACQ, REPORT, DONE} state_t;
  state_t state, next_state;
  logic [PHASE_W-1:0] f_step;
  logic [15:0] n_steps, index;
  logic [23:0] settle, settle_cnt;
  logic [3:0] k;
  logic signed [ACC_W-1:0] acc, acc_sum;
  logic [CNT_W-1:0] cnt, target;
  logic last_step, active;
  assign acc_sum   = acc + {{(ACC_W-DATA_W){lia_data_i[DATA_W-1]}}, lia_data_i};
  assign target    = CNT_W'(1) << k;
  assign last_step = index == n_steps - 16'd1;
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i)
    if (!dac_rstn_i) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (abort_i) next_state = IDLE;
    else case (state)
      IDLE:    if (start_i) next_state = (n_steps_i == 16'd0) ? DONE : SETTLE;
      SETTLE:  if (settle_cnt == 24'd0) next_state = ACQ;
      ACQ:     if (lia_valid_i && cnt + CNT_W'(1) == target) next_state = REPORT;
      REPORT:  next_state = last_step ? DONE : SETTLE;
      default: next_state = IDLE;
    endcase
  end
  always_comb active = next_state inside {SETTLE, ACQ, REPORT};
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i)
    if (!dac_rstn_i) begin
      phase_inc_o <= '0;
      gen_en_o    <= 1'b0;
      busy_o      <= 1'b0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_index_o <= '0;
      done_o      <= 1'b0;
      f_step      <= '0;
      n_steps     <= '0;
      settle      <= '0;
      settle_cnt  <= '0;
      k           <= '0;
      index       <= '0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      gen_en_o    <= active;
      busy_o      <= active;
      res_valid_o <= next_state == REPORT;
      done_o      <= next_state == DONE;
      if (state == IDLE && next_state != IDLE) begin
        f_step  <= f_step_i;
        n_steps <= n_steps_i;
        settle  <= settle_i;
        k       <= (avg_log2_i > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : avg_log2_i;
        index   <= '0;
        if (next_state == SETTLE) phase_inc_o <= f_start_i;
      end
      if (state == REPORT && next_state == SETTLE) begin
        phase_inc_o <= phase_inc_o + f_step;
        index       <= index + 16'd1;
      end
      if (next_state == SETTLE)
        settle_cnt <= (state == SETTLE) ? settle_cnt - 24'd1 : (state == IDLE ? settle_i : settle);
      if (state != ACQ) begin
        acc <= '0;
        cnt <= '0;
      end else if (lia_valid_i) begin
        acc <= acc_sum;
        cnt <= cnt + CNT_W'(1);
      end
      if (next_state == REPORT) begin
        res_data_o  <= DATA_W'(acc_sum >>> k);
        res_index_o <= index;
      end
    end
endmodule

// File: doc/lia_sweep_sequencer.md
# lia_sweep_sequencer

Sequences a frequency-swept lock-in measurement. It programs the signal generator's phase increment, enables the generator, and waits a programmable settling time. It then averages 2^k lock-in amplifier output samples and reports one result per frequency step. It sits between the processor-side register bank and the SignalGeneration / LockInAmplifier pair, in the 125 MHz DAC clock domain.

## Interface
Parameters:
- DATA_W, 14, width of LIA output and of reported result (signed)
- PHASE_W, 32, generator phase-increment width
- MAX_LOG2, 12, maximum averaging exponent k

Ports:
- dac_clk_i  in  1  single clock, all logic on rising edge
- dac_rstn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  starts a sweep when sampled high in IDLE
- abort_i  in  1  terminates any sweep, highest priority
- f_start_i  in  PHASE_W  phase increment of step 0
- f_step_i  in  PHASE_W  increment added per step
- n_steps_i  in  16  number of frequency steps
- settle_i  in  24  settle count S
- avg_log2_i  in  4  averaging exponent k
- lia_data_i  in  DATA_W  signed LIA output
- lia_valid_i  in  1  lia_data_i is a new sample
- phase_inc_o  out  PHASE_W  generator phase increment
- gen_en_o  out  1  generator enable
- busy_o  out  1  sweep in progress
- res_valid_o  out  1  one-cycle result strobe
- res_data_o  out  DATA_W  averaged result, signed
- res_index_o  out  16  step index of the result
- done_o  out  1  one-cycle end-of-sweep pulse

## Operation
- States: IDLE, SETTLE, ACQ, REPORT, DONE.
- On reset, all outputs are 0 and the state is IDLE. Reset is asserted asynchronously and released synchronously to the next edge.
- IDLE: when start_i=1, latch every configuration input. k is clamped to MAX_LOG2. Then:
  - n_steps_i=0: go to DONE. No results are produced and the generator stays disabled.
  - otherwise: set phase_inc_o=f_start_i and index=0, then go to SETTLE.
- Configuration inputs are ignored after latching. start_i is ignored outside IDLE.
- SETTLE: the settle counter loads S on entry and decrements once per cycle. The state exits to ACQ in the cycle the counter is 0, so SETTLE lasts exactly S+1 cycles. lia_valid_i is ignored.
- ACQ:
  - The accumulator (signed, DATA_W+MAX_LOG2+1 bits) is cleared on entry.
  - On each cycle with lia_valid_i=1, add the sign-extended lia_data_i and increment the sample count.
  - When the count reaches 2^k, go to REPORT.
  - Cycles without a valid sample do not count.
- REPORT (1 cycle):
  - res_valid_o=1.
  - res_data_o = acc >>> k, an arithmetic shift that rounds toward −inf.
  - res_index_o = index.
- Then:
  - if index = n_steps−1, go to DONE;
  - otherwise phase_inc_o += f_step (modulo 2^PHASE_W, wrapping silently), index += 1, go to SETTLE.
- DONE (1 cycle): done_o=1, gen_en_o=0, next state IDLE.
- gen_en_o and busy_o are 1 in SETTLE, ACQ and REPORT, and 0 in IDLE and DONE.
- phase_inc_o holds its last value in IDLE and after the sweep.
- res_data_o and res_index_o hold their values between strobes.
- abort_i=1 in any state:
  - next state is IDLE;
  - gen_en_o and busy_o go to 0 the next cycle;
  - no res_valid_o or done_o pulse is produced, even if abort coincides with REPORT.
- start_i and abort_i asserted together in IDLE: abort wins and the state stays IDLE.

## Timing
- All outputs are registered.
- If start_i is sampled at edge 0, the outputs change after edge 0, which is "cycle 1". busy_o, gen_en_o and phase_inc_o are valid in cycle 1.
- With valid samples every cycle, step j has this timeline (T = S + 2 + 2^k):
  - SETTLE occupies cycles 1 + jT … 1 + jT + S;
  - ACQ occupies the next 2^k cycles;
  - REPORT is cycle (j+1)·T.
- DONE is cycle n·T + 1.
- The new phase_inc_o appears in the cycle after REPORT, which is the first SETTLE cycle of the next step.
- n_steps=0: done_o is in cycle 1 and busy_o is never asserted.

## Test plan
- Basic sweep: f_start=1000, f_step=500, n=3, S=4, k=2, lia=100 valid every cycle.
  - res_valid_o in cycles 10, 20, 30, with res_data_o=100 and indices 0, 1, 2.
  - phase_inc_o = 1000, 1500, 2000.
  - done_o in cycle 31; busy_o high in cycles 1–30.
- Negative rounding: k=2, samples −3, −2, −2, −2 → res_data_o = −3. Samples 8191 ×4 → 8191 with no overflow.
- Valid gaps: k=1, lia_valid_i toggling every cycle with values 10 and 20 → res_data_o=15. REPORT is delayed by the gap cycles.
- Abort mid-ACQ of step 1, n=4 → IDLE next cycle, gen_en_o=0, no further res_valid_o, no done_o. A new start then runs a full sweep from index 0.
- Edge cases:
  - n=0 → done_o in cycle 1 with no result.
  - S=0 → SETTLE lasts 1 cycle.
  - avg_log2=15 → behaves as k=12 (4096 samples).
  - f_start=0xFFFF_FF00, f_step=0x200 → phase_inc_o=0x0000_0100 at step 1.
- Reset asserted during SETTLE → all outputs 0 immediately (asynchronously). start_i held high during the sweep does not restart it.
